nasti_narrower_reader: RTL and testbench

// - Read-path width narrower: wide NASTI master (AR/R) to narrow NASTI slave; companion of the narrower writer.
// - Splits each master read burst into one narrow INCR burst and packs narrow R beats back into master-width beats.
// - One outstanding transaction; sits between the wide crossbar port and narrow peripherals/memories.

---
 rtl/nasti_narrower_pkg.sv | 54 +++++
 rtl/nasti_narrower_reader_if.sv | 45 ++++
 rtl/nasti_narrower_rpack.sv | 99 +++++++++
 rtl/nasti_narrower_reader.sv | 172 +++++++++++++++++
 tb/tb_nasti_narrower_reader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nasti_narrower_pkg.sv
// Shared NASTI narrower definitions: latched request attributes, FSM
// states, response codes and the burst-narrowing arithmetic. Used by both
// the read and write narrowers.
package nasti_narrower_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width-independent AR/AW attributes; id/addr/user are held by the user
  // module because their widths are per-instance parameters.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } NastiReq;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} rd_state_e;

  // log2 of the number of slave beats per master beat
  function automatic int ratio_offset(input logic [2:0] size, input int scs);
    return (int'(size) > scs) ? int'(size) - scs : 0;
  endfunction

  function automatic int ratio(input logic [2:0] size, input int scs);
    return 1 << ratio_offset(size, scs);
  endfunction

  function automatic logic [2:0] slave_size(input logic [2:0] size, input int scs);
    return (int'(size) > scs) ? 3'(scs) : size;
  endfunction

  // Which slave-sized slot of the first master beat the address points at
  function automatic int burst_index(input logic [63:0] addr, input logic [2:0] size,
                                     input int scs);
    return int'((addr >> scs) & 64'(ratio(size, scs) - 1));
  endfunction

  // Narrow burst covers the rest of the first master beat plus all later ones
  function automatic logic [7:0] slave_len(input logic [7:0] len, input logic [2:0] size,
                                           input int scs, input int idx);
    if (ratio_offset(size, scs) == 0) return len;
    return 8'(((int'(len) + 1) << ratio_offset(size, scs)) - idx - 1);
  endfunction

endpackage

// File: rtl/nasti_narrower_reader_if.sv
// NASTI read channels (AR + R) for one side of the narrower.
interface nasti_narrower_reader_if #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_lock;
  logic [3:0]            ar_cache;
  logic [2:0]            ar_prot;
  logic [3:0]            ar_qos;
  logic [3:0]            ar_region;
  logic [USER_WIDTH-1:0] ar_user;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_narrower_rpack.sv
// Read pack buffer: narrow R beats are written into their lane of a
// master-width buffer, then presented through a one-entry valid/ready slice.
// NASTI_NARROWER_RD_RESP_MERGE_EN: report the worst resp of the packed beats
// instead of the resp of the completing beat.
module nasti_narrower_rpack
  import nasti_narrower_pkg::*;
#(
  parameter int NLANES     = 2,
  parameter int SDW        = 32,
  parameter int USER_WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,   // slave R handshake
  output logic                         in_ready_o,
  input  logic [$clog2(NLANES)-1:0]    lane_i,
  input  logic                         start_i,      // first slave beat of a master beat
  input  logic                         complete_i,   // last slave beat of a master beat
  input  logic [SDW-1:0]               data_i,
  input  logic [1:0]                   resp_i,
  input  logic                         last_i,
  input  logic [USER_WIDTH-1:0]        user_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NLANES-1:0][SDW-1:0]   out_data_o,
  output logic [1:0]                   out_resp_o,
  output logic                         out_last_o,
  output logic [USER_WIDTH-1:0]        out_user_o
);
  localparam int LW = $clog2(NLANES);

  logic                  out_valid_q;
  logic [1:0]            resp_q, resp_d;
  logic                  last_q;
  logic [USER_WIDTH-1:0] user_q;

  // Draining and refilling in the same cycle is allowed
  assign in_ready_o = !out_valid_q || out_ready_i;

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    logic [SDW-1:0] q;
    // Lane capture; a new master beat clears lanes it does not write
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                  q <= '0;
      else if (in_valid_i) begin
        if (lane_i == LW'(l))   q <= data_i;
        else if (start_i)       q <= '0;
      end
    end
    assign out_data_o[l] = q;
  end

`ifdef NASTI_NARROWER_RD_RESP_MERGE_EN
  logic [1:0] acc_q;

  function automatic logic [1:0] resp_norm(input logic [1:0] r);
    return (r == RESP_EXOKAY) ? RESP_OKAY : r;
  endfunction

  // With EXOKAY folded to OKAY the encoding orders by severity
  function automatic logic [1:0] resp_worse(input logic [1:0] a, input logic [1:0] b);
    return (resp_norm(a) > resp_norm(b)) ? resp_norm(a) : resp_norm(b);
  endfunction

  // Running worst resp of the master beat being assembled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             acc_q <= RESP_OKAY;
    else if (in_valid_i) acc_q <= start_i ? resp_norm(resp_i) : resp_worse(acc_q, resp_i);
  end

  // A single-beat master beat passes its resp through untouched
  assign resp_d = start_i ? resp_i : resp_worse(acc_q, resp_i);
`else
  assign resp_d = resp_i;
`endif

  // Output slice: set on the completing beat, cleared when drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      resp_q      <= RESP_OKAY;
      last_q      <= 1'b0;
      user_q      <= '0;
    end else if (in_valid_i && complete_i) begin
      out_valid_q <= 1'b1;
      resp_q      <= resp_d;
      last_q      <= last_i;
      user_q      <= user_i;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_resp_o  = resp_q;
  assign out_last_o  = last_q;
  assign out_user_o  = user_q;

endmodule

// File: rtl/nasti_narrower_reader.sv
// Read-path width narrower: one wide AR becomes one narrow INCR AR, and the
// narrow R beats are packed back into master-width beats. One transaction
// in flight. Optional: NASTI_NARROWER_RD_RESP_MERGE_EN (resp merging).
module nasti_narrower_reader
  import nasti_narrower_pkg::*;
#(
  parameter int ID_WIDTH          = 2,
  parameter int ADDR_WIDTH        = 32,
  parameter int MASTER_DATA_WIDTH = 64,
  parameter int SLAVE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH        = 1
) (
  input logic                     clk,
  input logic                     rst,
  nasti_narrower_reader_if.slave  master,
  nasti_narrower_reader_if.master slave
);
  localparam int MCS    = $clog2(MASTER_DATA_WIDTH / 8);
  localparam int SCS    = $clog2(SLAVE_DATA_WIDTH / 8);
  localparam int NLANES = MASTER_DATA_WIDTH / SLAVE_DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  rd_state_e             state_q, state_d;
  NastiReq               req_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            beat_cnt_q;
  logic                  start_q;
  logic                  done_q;

  logic ar_hs, sar_hs, sr_hs, mr_hs;
  logic in_ready;
  logic complete;
  logic [2:0]            ssize;
  logic [7:0]            slen;
  logic [ADDR_WIDTH-1:0] size_mask, sbytes;
  logic [MCS-SCS-1:0]    lane;
  logic [NLANES-1:0][SLAVE_DATA_WIDTH-1:0] pack_data;
  logic                  unused_r_id;

  assign ar_hs  = master.ar_valid && master.ar_ready;
  assign sar_hs = slave.ar_valid && slave.ar_ready;
  assign sr_hs  = slave.r_valid && slave.r_ready;
  assign mr_hs  = master.r_valid && master.r_ready;
  assign unused_r_id = ^slave.r_id;

  assign ssize = slave_size(req_q.size, SCS);
  assign slen  = slave_len(req_q.len, req_q.size, SCS,
                           burst_index(64'(addr_q), req_q.size, SCS));

  // Beat bookkeeping on the running narrow address
  assign size_mask = (ONE << req_q.size) - ONE;
  assign sbytes    = ONE << ssize;
  assign lane      = r_addr_q[MCS-1:SCS];
  assign complete  = (((r_addr_q & size_mask) + sbytes) > size_mask) || slave.r_last;
  assign r_addr_d  = (r_addr_q & ~(sbytes - ONE)) + sbytes;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ar_hs)                   state_d = S_AR;
      S_AR:    if (sar_hs)                  state_d = S_R;
      S_R:     if (mr_hs && master.r_last)  state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  // FSM outputs; slave R is throttled once the last narrow beat is taken
  always_comb begin
    master.ar_ready = (state_q == S_IDLE);
    slave.ar_valid  = (state_q == S_AR);
    slave.r_ready   = (state_q == S_R) && !done_q && in_ready;
  end

  // Request latch and per-beat address/counter tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      user_q     <= '0;
      r_addr_q   <= '0;
      beat_cnt_q <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
    end else if (ar_hs) begin
      req_q      <= '{len: master.ar_len, size: master.ar_size, burst: master.ar_burst,
                      lock: master.ar_lock, cache: master.ar_cache, prot: master.ar_prot,
                      qos: master.ar_qos, region: master.ar_region};
      id_q       <= master.ar_id;
      addr_q     <= master.ar_addr;
      user_q     <= master.ar_user;
      r_addr_q   <= master.ar_addr;
      beat_cnt_q <= '0;
      start_q    <= 1'b1;
      done_q     <= 1'b0;
    end else if (sr_hs) begin
      r_addr_q   <= r_addr_d;
      beat_cnt_q <= beat_cnt_q + 8'd1;
      start_q    <= complete;
      if (slave.r_last) done_q <= 1'b1;
    end
  end

  assign slave.ar_id     = id_q;
  assign slave.ar_addr   = addr_q;
  assign slave.ar_len    = slen;
  assign slave.ar_size   = ssize;
  assign slave.ar_burst  = req_q.burst;
  assign slave.ar_lock   = req_q.lock;
  assign slave.ar_cache  = req_q.cache;
  assign slave.ar_prot   = req_q.prot;
  assign slave.ar_qos    = req_q.qos;
  assign slave.ar_region = req_q.region;
  assign slave.ar_user   = user_q;

  nasti_narrower_rpack #(
    .NLANES     (NLANES),
    .SDW        (SLAVE_DATA_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_rpack (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (sr_hs),
    .in_ready_o  (in_ready),
    .lane_i      (lane),
    .start_i     (start_q),
    .complete_i  (complete),
    .data_i      (slave.r_data),
    .resp_i      (slave.r_resp),
    .last_i      (slave.r_last),
    .user_i      (slave.r_user),
    .out_valid_o (master.r_valid),
    .out_ready_i (master.r_ready),
    .out_data_o  (pack_data),
    .out_resp_o  (master.r_resp),
    .out_last_o  (master.r_last),
    .out_user_o  (master.r_user)
  );

  assign master.r_data = pack_data;
  assign master.r_id   = id_q;

`ifndef SYNTHESIS
  // Simulation-only protocol checks on accepted requests and narrow beats
  always @(posedge clk) begin
    if (!rst && ar_hs) begin
      assert (master.ar_burst == BURST_INCR)
        else $fatal(1, "nasti_narrower_reader: only INCR bursts supported");
      assert (int'(master.ar_size) <= MCS)
        else $fatal(1, "nasti_narrower_reader: ar_size exceeds master width");
      assert (((32'(master.ar_len) + 32'd1) << master.ar_size) <= 32'(32 * SLAVE_DATA_WIDTH))
        else $fatal(1, "nasti_narrower_reader: burst too long");
    end
    if (!rst && sr_hs) begin
      assert (slave.r_last == (beat_cnt_q == slen))
        else $error("nasti_narrower_reader: slave r_last at beat %0d, expected at %0d",
                    beat_cnt_q, slen);
    end
  end
`endif

endmodule

// File: tb/tb_nasti_narrower_reader.sv
module tb_nasti_narrower_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nasti_narrower_reader_if #(.ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .USER_WIDTH(1)) mif ();
  nasti_narrower_reader_if #(.ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(1)) sif ();

  nasti_narrower_reader #(
    .ID_WIDTH(2), .ADDR_WIDTH(32), .MASTER_DATA_WIDTH(64), .SLAVE_DATA_WIDTH(32), .USER_WIDTH(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .master (mif),
    .slave  (sif)
  );

  int compared = 0;
  int mism     = 0;

  // slave-side stimulus tables
  logic [31:0] sdata [16];
  logic [1:0]  sresp [16];

  // handshakes seen at negedge (they complete at the following posedge)
  logic        ar_hs_s, r_hs_s;
  logic [7:0]  cap_len;
  logic [2:0]  cap_size;
  logic [31:0] cap_addr;
  int          s_hs_cnt = 0;
  int          s_stall  = 0;
  logic [69:0] mq[$];   // {id, user, last, resp, data}

  always @(negedge clk) begin
    ar_hs_s = sif.ar_valid && sif.ar_ready;
    if (ar_hs_s) begin cap_len = sif.ar_len; cap_size = sif.ar_size; cap_addr = sif.ar_addr; end
    r_hs_s = sif.r_valid && sif.r_ready;
    if (r_hs_s) s_hs_cnt++;
    if (!rst && sif.r_valid && !sif.r_ready) s_stall++;
    if (mif.r_valid && mif.r_ready)
      mq.push_back({mif.r_id, mif.r_user, mif.r_last, mif.r_resp, mif.r_data});
  end

  // narrow slave: streams sdata[0..len] back-to-back after its AR
  initial begin : slave_model
    int  sidx;
    int  slen;
    bit  sbusy;
    sidx = 0; slen = 0; sbusy = 0;
    sif.ar_ready = 1'b0; sif.r_valid = 1'b0; sif.r_id = '0; sif.r_data = '0;
    sif.r_resp = '0; sif.r_last = 1'b0; sif.r_user = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        sbusy = 0; sidx = 0; sif.ar_ready = 1'b0; sif.r_valid = 1'b0;
      end else begin
        if (ar_hs_s) begin sbusy = 1; sidx = 0; slen = int'(cap_len); end
        else if (r_hs_s) sidx++;
        if (sbusy && sidx <= slen) begin
          sif.r_valid = 1'b1;
          sif.r_data  = sdata[sidx];
          sif.r_resp  = sresp[sidx];
          sif.r_last  = (sidx == slen);
          sif.r_user  = 1'(sidx % 2);
          sif.r_id    = 2'd3;
        end else begin
          sif.r_valid = 1'b0;
          sif.r_last  = 1'b0;
          sbusy = 0;
        end
        sif.ar_ready = !sbusy;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_ar(input logic [1:0] id, input logic [31:0] addr,
                       input logic [2:0] size, input logic [7:0] len);
    int n;
    @(posedge clk); #1;
    mif.ar_id = id; mif.ar_addr = addr; mif.ar_size = size; mif.ar_len = len;
    mif.ar_burst = 2'b01; mif.ar_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (mif.ar_ready !== 1'b1 && n < 20);
    chk("ar_accept", 64'(mif.ar_ready), 64'd1);
    @(posedge clk); #1;
    mif.ar_valid = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n);
    int k;
    k = 0;
    while (mq.size() < n && k < 200) begin @(negedge clk); k++; end
    chk(tag, 64'(mq.size()), 64'(n));
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] d, input logic l,
                          input logic [1:0] r);
    logic [69:0] b;
    compared++;
    assert (mq.size() != 0) else begin
      mism++;
      $error("FAIL %s: got no beat want data %h", tag, d);
    end
    if (mq.size() != 0) begin
      b = mq.pop_front();
      chk({tag, "_data"}, b[63:0], d);
      chk({tag, "_last"}, 64'(b[66]), 64'(l));
      chk({tag, "_resp"}, 64'(b[65:64]), 64'(r));
    end
  endtask

  task automatic load_aligned(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin sdata[i] = base * 32'(i + 1); sresp[i] = 2'b00; end
  endtask

  initial begin : main
    logic [69:0] b;
    int st0, hs0, k;
    logic [1:0] exp_r0, exp_r1;

    rst = 1'b1;
    mif.ar_id = '0; mif.ar_addr = '0; mif.ar_len = '0; mif.ar_size = '0; mif.ar_burst = 2'b01;
    mif.ar_lock = 1'b0; mif.ar_cache = '0; mif.ar_prot = '0; mif.ar_qos = '0;
    mif.ar_region = '0; mif.ar_user = '0; mif.ar_valid = 1'b0; mif.r_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin sdata[i] = '0; sresp[i] = '0; end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_ready", 64'(mif.ar_ready), 64'd1);
    chk("rst_r_valid",  64'(mif.r_valid),  64'd0);
    chk("rst_sar_valid", 64'(sif.ar_valid), 64'd0);
    chk("rst_sr_ready", 64'(sif.r_ready),  64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // aligned: 0x100, size 3, len 3 -> slave len 7 size 2
    load_aligned(32'h11);
    st0 = s_stall;
    do_ar(2'd2, 32'h100, 3'd3, 8'd3);
    wait_beats("a_count", 4);
    chk("a_slen",  64'(cap_len),  64'd7);
    chk("a_ssize", 64'(cap_size), 64'd2);
    chk("a_saddr", 64'(cap_addr), 64'h100);
    chk("a_id",   64'(mq[0][69:68]), 64'd2);
    chk("a_user", 64'(mq[0][67]),    64'd1);
    chk_beat("a0", 64'h00000022_00000011, 1'b0, 2'b00);
    chk_beat("a1", 64'h00000044_00000033, 1'b0, 2'b00);
    chk_beat("a2", 64'h00000066_00000055, 1'b0, 2'b00);
    chk_beat("a3", 64'h00000088_00000077, 1'b1, 2'b00);
    chk("a_stalls", 64'(s_stall - st0), 64'd0);
    @(negedge clk);
    chk("a_idle", 64'(mif.ar_ready), 64'd1);

    // unaligned: 0x104, size 3, len 1 -> slave len 2
    sdata[0] = 32'hA0A0A0A0; sdata[1] = 32'hB1B1B1B1; sdata[2] = 32'hC2C2C2C2;
    do_ar(2'd1, 32'h104, 3'd3, 8'd1);
    wait_beats("u_count", 2);
    chk("u_slen", 64'(cap_len), 64'd2);
    chk("u_user", 64'(mq[0][67]), 64'd0);
    chk_beat("u0", 64'hA0A0A0A0_00000000, 1'b0, 2'b00);
    chk_beat("u1", 64'hC2C2C2C2_B1B1B1B1, 1'b1, 2'b00);

    // narrow: 0x106, size 1 -> slave size 1 len 0; addr bit 2 selects the upper lane;
    // single-beat EXOKAY passes through
    sdata[0] = 32'hABCD0000; sresp[0] = 2'b01;
    do_ar(2'd0, 32'h106, 3'd1, 8'd0);
    wait_beats("n_count", 1);
    chk("n_slen",  64'(cap_len),  64'd0);
    chk("n_ssize", 64'(cap_size), 64'd1);
    chk_beat("n0", 64'hABCD0000_00000000, 1'b1, 2'b01);

    // response handling across two master beats
    sdata[0] = 32'h1; sdata[1] = 32'h2; sdata[2] = 32'h3; sdata[3] = 32'h4;
    sresp[0] = 2'b10; sresp[1] = 2'b00; sresp[2] = 2'b00; sresp[3] = 2'b01;
`ifdef NASTI_NARROWER_RD_RESP_MERGE_EN
    exp_r0 = 2'b10; exp_r1 = 2'b00;
`else
    exp_r0 = 2'b00; exp_r1 = 2'b01;
`endif
    do_ar(2'd0, 32'h100, 3'd3, 8'd1);
    wait_beats("r_count", 2);
    chk("r_slen", 64'(cap_len), 64'd3);
    chk_beat("r0", 64'h00000002_00000001, 1'b0, exp_r0);
    chk_beat("r1", 64'h00000004_00000003, 1'b1, exp_r1);

    // backpressure: master stalls 5 cycles after the first packed beat
    load_aligned(32'h01010101);
    do_ar(2'd0, 32'h100, 3'd3, 8'd3);
    wait_beats("b_first", 1);
    @(posedge clk); #1; mif.r_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b_sr_ready", 64'(sif.r_ready), 64'd0);
    chk("b_mr_valid", 64'(mif.r_valid), 64'd1);
    repeat (4) @(posedge clk);
    #1; mif.r_ready = 1'b1;
    wait_beats("b_count", 4);
    chk_beat("b0", 64'h02020202_01010101, 1'b0, 2'b00);
    chk_beat("b1", 64'h04040404_03030303, 1'b0, 2'b00);
    chk_beat("b2", 64'h06060606_05050505, 1'b0, 2'b00);
    chk_beat("b3", 64'h08080808_07070707, 1'b1, 2'b00);
    repeat (5) @(negedge clk);
    chk("b_no_dup", 64'(mq.size()), 64'd0);

    // reset pulse after 3 slave beats in S_R
    load_aligned(32'h10);
    hs0 = s_hs_cnt;
    do_ar(2'd0, 32'h100, 3'd3, 8'd3);
    k = 0;
    while (s_hs_cnt - hs0 < 3 && k < 100) begin @(negedge clk); k++; end
    chk("x_3beats", 64'(s_hs_cnt - hs0), 64'd3);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("x_r_valid",  64'(mif.r_valid),  64'd0);
    chk("x_ar_ready", 64'(mif.ar_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    mq.delete();

    // next burst after the abort completes normally
    load_aligned(32'h11);
    do_ar(2'd3, 32'h100, 3'd3, 8'd3);
    wait_beats("p_count", 4);
    chk("p_id", 64'(mq[0][69:68]), 64'd3);
    chk_beat("p0", 64'h00000022_00000011, 1'b0, 2'b00);
    chk_beat("p1", 64'h00000044_00000033, 1'b0, 2'b00);
    chk_beat("p2", 64'h00000066_00000055, 1'b0, 2'b00);
    chk_beat("p3", 64'h00000088_00000077, 1'b1, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
